pipeline_ctrl: RTL

//  Parametrised control core for an N-stage in-order MIPS pipeline.
//  - Tracks valid/destination scoreboard per stage; generates forwarding selects, load-use stall and branch flush.
//  - Debug run/halt/single-step sequencer replaces the raw pc enable.
//  - Sits beside the datapath stages and drives their enables and bubble controls.

---
 rtl/pipeline_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Control core for an N-stage in-order MIPS pipeline: scoreboard, load-use stall, branch flush,
// operand forwarding and a debug run/halt/step sequencer. Optional perf counters: PIPELINE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int NUM_STAGES    = 5,
    parameter int REG_ADDR_BITS = 5,
    parameter int FW_BUS_WIDTH  = 2,
    parameter int BRANCH_STAGE  = 3,
    parameter int LOAD_STAGE    = 4,
    parameter bit RESET_HALTED  = 1'b0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [REG_ADDR_BITS-1:0] id_rs_addr,
    input  logic [REG_ADDR_BITS-1:0] id_rt_addr,
    input  logic [REG_ADDR_BITS-1:0] id_w_addr,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     br_taken,
    input  logic                     dbg_halt,
    input  logic                     dbg_step,
    input  logic                     dbg_resume,
    output logic                     pc_enable,
    output logic                     ifid_enable,
    output logic                     stage_enable,
    output logic                     ex_bubble,
    output logic [NUM_STAGES-1:0]    flush_mask,
    output logic [FW_BUS_WIDTH-1:0]  fw_rs_sel,
    output logic [FW_BUS_WIDTH-1:0]  fw_rt_sel,
    output logic                     halted,
    output logic                     wb_valid
`ifdef PIPELINE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     perf_retired,
    output logic [CNT_WIDTH-1:0]     perf_stalls,
    output logic [CNT_WIDTH-1:0]     perf_flushes
`endif
);

    localparam int LAST = NUM_STAGES - 1;
    localparam logic [NUM_STAGES-1:0] FLUSH_BITS = NUM_STAGES'((1 << BRANCH_STAGE) - 1);

    if (NUM_STAGES < 4 || NUM_STAGES > 8 || BRANCH_STAGE < 2 || BRANCH_STAGE > NUM_STAGES - 2 ||
        LOAD_STAGE < 3 || LOAD_STAGE > NUM_STAGES - 1 || (1 << FW_BUS_WIDTH) < NUM_STAGES - 2 ||
        CNT_WIDTH < 1) begin : g_cfg_err
        $error("pipeline_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        SEQ_RUN  = 2'd0,
        SEQ_HALT = 2'd1,
        SEQ_STEP = 2'd2
    } seq_t;

    localparam seq_t SEQ_RESET = RESET_HALTED ? SEQ_HALT : SEQ_RUN;

    seq_t r_seq;
    seq_t w_seq_nxt;
    logic w_adv;
    logic w_hazard;
    logic w_stall;

    // Scoreboard entries 2..LAST; index equals the stage the instruction occupies.
    logic                     r_valid     [2:LAST];
    logic [REG_ADDR_BITS-1:0] r_rs        [2:LAST];
    logic [REG_ADDR_BITS-1:0] r_rt        [2:LAST];
    logic [REG_ADDR_BITS-1:0] r_w_addr    [2:LAST];
    logic                     r_uses_rs   [2:LAST];
    logic                     r_uses_rt   [2:LAST];
    logic                     r_reg_write [2:LAST];
    logic                     r_mem_read  [2:LAST];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq <= SEQ_RESET;
        end else begin
            r_seq <= w_seq_nxt;
        end
    end

    always_comb begin
        w_seq_nxt = r_seq;
        case (r_seq)
            SEQ_RUN: begin
                if (dbg_halt) w_seq_nxt = SEQ_HALT;
            end
            SEQ_HALT: begin
                if (dbg_halt)        w_seq_nxt = SEQ_HALT;
                else if (dbg_step)   w_seq_nxt = SEQ_STEP;
                else if (dbg_resume) w_seq_nxt = SEQ_RUN;
            end
            SEQ_STEP: w_seq_nxt = SEQ_HALT;
            default:  w_seq_nxt = SEQ_RESET;
        endcase
    end

    always_comb begin
        w_adv  = 1'b1;
        halted = 1'b0;
        case (r_seq)
            SEQ_HALT: begin
                w_adv  = 1'b0;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    // A load still short of LOAD_STAGE cannot supply its data to the instruction in ID.
    always_comb begin
        w_hazard = 1'b0;
        for (int j = 2; j < LOAD_STAGE; j++) begin
            if (r_valid[j] && r_mem_read[j] && r_reg_write[j] && (r_w_addr[j] != '0) &&
                ((id_uses_rs && (r_w_addr[j] == id_rs_addr)) ||
                 (id_uses_rt && (r_w_addr[j] == id_rt_addr)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_stall      = w_hazard & ~br_taken;
    assign stage_enable = w_adv;
    assign pc_enable    = w_adv & ~w_stall;
    assign ifid_enable  = w_adv & ~w_stall;
    assign ex_bubble    = w_adv & w_stall;
    assign flush_mask   = br_taken ? FLUSH_BITS : '0;
    assign wb_valid     = r_valid[LAST];

    // Scan oldest to youngest so the lowest matching stage is the last writer.
    always_comb begin
        fw_rs_sel = '0;
        fw_rt_sel = '0;
        for (int k = LAST; k >= 3; k--) begin
            if (r_valid[2] && r_valid[k] && r_reg_write[k] && (r_w_addr[k] != '0)) begin
                if (r_uses_rs[2] && (r_w_addr[k] == r_rs[2])) fw_rs_sel = FW_BUS_WIDTH'(k - 2);
                if (r_uses_rt[2] && (r_w_addr[k] == r_rt[2])) fw_rt_sel = FW_BUS_WIDTH'(k - 2);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 2; k <= LAST; k++) r_valid[k] <= 1'b0;
        end else if (w_adv) begin
            r_valid[2] <= ~(ex_bubble | flush_mask[1]);
            for (int k = 3; k <= LAST; k++) r_valid[k] <= r_valid[k-1] & ~flush_mask[k-1];
        end
    end

    // Payload fields only matter while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_rs[2]        <= id_rs_addr;
            r_rt[2]        <= id_rt_addr;
            r_w_addr[2]    <= id_w_addr;
            r_uses_rs[2]   <= id_uses_rs;
            r_uses_rt[2]   <= id_uses_rt;
            r_reg_write[2] <= id_reg_write;
            r_mem_read[2]  <= id_mem_read;
            for (int k = 3; k <= LAST; k++) begin
                r_rs[k]        <= r_rs[k-1];
                r_rt[k]        <= r_rt[k-1];
                r_w_addr[k]    <= r_w_addr[k-1];
                r_uses_rs[k]   <= r_uses_rs[k-1];
                r_uses_rt[k]   <= r_uses_rt[k-1];
                r_reg_write[k] <= r_reg_write[k-1];
                r_mem_read[k]  <= r_mem_read[k-1];
            end
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_retired;
    logic [CNT_WIDTH-1:0] r_stalls;
    logic [CNT_WIDTH-1:0] r_flushes;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
            r_stalls  <= '0;
            r_flushes <= '0;
        end else if (w_adv) begin
            if (wb_valid) r_retired <= r_retired + 1'b1;
            if (w_stall)  r_stalls  <= r_stalls + 1'b1;
            if (br_taken) r_flushes <= r_flushes + 1'b1;
        end
    end

    assign perf_retired = r_retired;
    assign perf_stalls  = r_stalls;
    assign perf_flushes = r_flushes;
`endif

endmodule
